fft_2d_out_collector: RTL and testbench

- Receive-side companion to the 2-D FFT/IFFT array. It sits on the core's output side: it watches the core's `next_out` strobe, captures the streamed WIDTH x WIDTH result beats, and parks them in a two-tile ping-pong buffer.
- It re-issues each tile downstream as FRAME_CYCLES beats on a valid/ready stream, framed with a last flag.
- The FFT core cannot stall, so the write side never backpressures. Lost tiles and protocol violations are reported through sticky flags.

---
 rtl/fft_collect_pkg.sv | 23 ++
 rtl/fft_collect_tile_bank.sv | 28 ++
 rtl/fft_2d_out_collector.sv | 186 ++++++++++++++++++
 tb/tb_fft_2d_out_collector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_collect_pkg.sv
// Shared types and default sizing for the 2-D FFT output collector.
// Holds the write-side state encoding and the beat/counter width helpers.
package fft_collect_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_CAPTURE,
        W_DROP
    } wstate_e;

    localparam int WIDTH_DEF        = 4;
    localparam int DATA_WIDTH_DEF   = 16;
    localparam int FRAME_CYCLES_DEF = 2;

    // Beat counters stay at least one bit wide even for single-beat tiles.
    function automatic int cnt_bits(input int frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

    localparam int BEAT_BITS = WIDTH_DEF * WIDTH_DEF * DATA_WIDTH_DEF;
    localparam int CNT_BITS  = cnt_bits(FRAME_CYCLES_DEF);

endpackage

// File: rtl/fft_collect_tile_bank.sv
// One tile of storage: FRAMES beats of BEAT_W bits, written one beat per cycle.
// Contents are never reset; the owner tracks validity with its own full flag.
module fft_tile_bank
    import fft_collect_pkg::*;
#(
    parameter int FRAMES = FRAME_CYCLES_DEF,
    parameter int BEAT_W = BEAT_BITS,
    parameter int CNT_W  = CNT_BITS
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [CNT_W-1:0]  wbeat_i,
    input  logic [BEAT_W-1:0] wdata_i,
    input  logic [CNT_W-1:0]  rbeat_i,
    output logic [BEAT_W-1:0] rdata_o
);

    logic [BEAT_W-1:0] mem_q [FRAMES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wbeat_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rbeat_i];

endmodule

// File: rtl/fft_2d_out_collector.sv
// Captures FFT core output tiles into a two-bank ping-pong buffer and replays
// each tile on a valid/ready stream; the capture side never stalls the core.
module fft_2d_out_collector
    import fft_collect_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              fft_next_out,
    input  logic [WIDTH*WIDTH*DATA_WIDTH-1:0] fft_out,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [WIDTH*WIDTH*DATA_WIDTH-1:0] m_data,
    output logic                              m_last,
    output logic                              overflow,
    output logic                              proto_err,
    output logic                              busy
);

    localparam int BEAT_W = WIDTH * WIDTH * DATA_WIDTH;
    localparam int CNT_W  = cnt_bits(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    wstate_e          state_q, state_d;
    logic [CNT_W-1:0] wbeat_q, wbeat_d;
    logic [CNT_W-1:0] rbeat_q, rbeat_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             perr_q, perr_d;

    logic [1:0]       set_full;
    logic [1:0]       clr_full;
    logic [1:0]       free;
    logic             rel;
    logic             wr_last;
    logic             cap_we;
    logic [BEAT_W-1:0] rdata0, rdata1;

    assign m_valid = full_q[rd_ptr_q];
    assign rel     = m_valid && m_ready && (rbeat_q == LAST);
    assign wr_last = (wbeat_q == LAST);
    assign cap_we  = (state_q == W_CAPTURE);

    // A bank that finishes draining this cycle is already free for a new tile.
    assign free[0] = !full_q[0] || (rel && !rd_ptr_q);
    assign free[1] = !full_q[1] || (rel &&  rd_ptr_q);

    always_comb begin
        state_d  = state_q;
        wbeat_d  = wbeat_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        perr_d   = perr_q;
        set_full = 2'b00;
        case (state_q)
            W_IDLE: begin
                if (fft_next_out) begin
                    wbeat_d = '0;
                    if (free[wr_ptr_q]) begin
                        state_d = W_CAPTURE;
                    end else begin
                        state_d = W_DROP;
                        ovf_d   = 1'b1;
                    end
                end
            end
            W_CAPTURE: begin
                if (wr_last) begin
                    set_full[wr_ptr_q] = 1'b1;
                    wr_ptr_d           = !wr_ptr_q;
                    wbeat_d            = '0;
                    if (!fft_next_out) begin
                        state_d = W_IDLE;
                    end else if (free[!wr_ptr_q]) begin
                        state_d = W_CAPTURE;
                    end else begin
                        state_d = W_DROP;
                        ovf_d   = 1'b1;
                    end
                end else begin
                    wbeat_d = wbeat_q + 1'b1;
                    if (fft_next_out) begin
                        perr_d = 1'b1;
                    end
                end
            end
            W_DROP: begin
                if (wr_last) begin
                    wbeat_d = '0;
                    if (!fft_next_out) begin
                        state_d = W_IDLE;
                    end else if (free[wr_ptr_q]) begin
                        state_d = W_CAPTURE;
                    end else begin
                        state_d = W_DROP;
                        ovf_d   = 1'b1;
                    end
                end else begin
                    wbeat_d = wbeat_q + 1'b1;
                    if (fft_next_out) begin
                        perr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        rbeat_d  = rbeat_q;
        rd_ptr_d = rd_ptr_q;
        clr_full = 2'b00;
        if (m_valid && m_ready) begin
            if (rbeat_q == LAST) begin
                rbeat_d            = '0;
                rd_ptr_d           = !rd_ptr_q;
                clr_full[rd_ptr_q] = 1'b1;
            end else begin
                rbeat_d = rbeat_q + 1'b1;
            end
        end
        full_d = (full_q & ~clr_full) | set_full;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= W_IDLE;
            wbeat_q  <= '0;
            rbeat_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= 2'b00;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wbeat_q  <= wbeat_d;
            rbeat_q  <= rbeat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
        end
    end

    fft_tile_bank #(
        .FRAMES (FRAME_CYCLES),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_bank0 (
        .clk     (clk),
        .we_i    (cap_we && !wr_ptr_q),
        .wbeat_i (wbeat_q),
        .wdata_i (fft_out),
        .rbeat_i (rbeat_q),
        .rdata_o (rdata0)
    );

    fft_tile_bank #(
        .FRAMES (FRAME_CYCLES),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_bank1 (
        .clk     (clk),
        .we_i    (cap_we && wr_ptr_q),
        .wbeat_i (wbeat_q),
        .wdata_i (fft_out),
        .rbeat_i (rbeat_q),
        .rdata_o (rdata1)
    );

    assign m_data    = rd_ptr_q ? rdata1 : rdata0;
    assign m_last    = m_valid && (rbeat_q == LAST);
    assign overflow  = ovf_q;
    assign proto_err = perr_q;
    assign busy      = (state_q != W_IDLE) || (|full_q);

endmodule

// File: tb/tb_fft_2d_out_collector.sv
// Directed bench for fft_2d_out_collector: scheduled core strobes/beats feed a
// scoreboard queue; a negedge monitor checks every accepted output beat.
module tb_fft_2d_out_collector;

    localparam int BW = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fft_next_out = 1'b0;
    logic [BW-1:0] fft_out = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [BW-1:0] m_data;
    logic          m_last;
    logic          overflow;
    logic          proto_err;
    logic          busy;

    fft_2d_out_collector #(
        .WIDTH        (4),
        .DATA_WIDTH   (16),
        .FRAME_CYCLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fft_next_out (fft_next_out),
        .fft_out      (fft_out),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .overflow     (overflow),
        .proto_err    (proto_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int base   = 0;
    int mon_beats = 0;
    bit hold_rst = 1'b0;

    bit            strobe_a [int];
    bit            rst_a    [int];
    logic [BW-1:0] data_a   [int];
    logic [BW:0]   exp_q    [$];

    // Word j of beat b in tile t is {t, b, 0, j}; tile 0 gives 16'h0b0j.
    function automatic logic [BW-1:0] beat(input int t, input int b);
        logic [BW-1:0] v;
        logic [3:0] tn, bn, jn;
        v  = '0;
        tn = 4'(t);
        bn = 4'(b);
        for (int j = 0; j < 16; j++) begin
            jn = 4'(j);
            v[j*16 +: 16] = {tn, bn, 4'h0, jn};
        end
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc - base + 1, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        fft_next_out = strobe_a.exists(cyc + 1);
        fft_out      = data_a.exists(cyc + 1) ? data_a[cyc + 1] : {16{16'hDEAD}};
        reset        = !(hold_rst || rst_a.exists(cyc + 1));
    endtask

    // Returns just after edge N-1: outputs shown are those of cycle N, and
    // inputs set now are sampled at edge N.
    task automatic at(input int r);
        while (cyc < base + r - 1) tick();
    endtask

    task automatic sched(input int r, input int tile);
        strobe_a[base + r]   = 1'b1;
        data_a[base + r + 1] = beat(tile, 0);
        data_a[base + r + 2] = beat(tile, 1);
    endtask

    task automatic push_tile(input int tile);
        exp_q.push_back({1'b0, beat(tile, 0)});
        exp_q.push_back({1'b1, beat(tile, 1)});
    endtask

    task automatic do_reset(input string tag);
        hold_rst = 1'b1;
        reset    = 1'b0;
        m_ready  = 1'b0;
        repeat (3) tick();
        chk({tag, "_rst_valid"}, int'(m_valid), 0);
        chk({tag, "_rst_last"},  int'(m_last), 0);
        chk({tag, "_rst_ovf"},   int'(overflow), 0);
        chk({tag, "_rst_perr"},  int'(proto_err), 0);
        chk({tag, "_rst_busy"},  int'(busy), 0);
        hold_rst = 1'b0;
        reset    = 1'b1;
        base     = cyc;
    endtask

    // Scoreboard monitor plus hold-stable check under backpressure.
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_chk++;
                if (!m_valid || m_data !== prev_data || m_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%0b last=%0b data=%h required valid=1 last=%0b data=%h",
                             m_valid, m_last, m_data, prev_last, prev_data);
                end
            end
            if (m_valid && m_ready) begin
                logic [BW:0] e;
                n_chk++;
                mon_beats++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: last=%0b data=%h with empty scoreboard", m_last, m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        n_fail++;
                        $display("FAIL beat_%0d: last=%0b data=%h required last=%0b data=%h",
                                 mon_beats, m_last, m_data, e[BW], e[BW-1:0]);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, required completion");
        $fatal(1);
    end

    initial begin
        // Single tile with downstream always ready
        do_reset("t1");
        m_ready = 1'b1;
        sched(10, 0);
        push_tile(0);
        at(11); chk("t1_busy_capture", int'(busy), 1);
        at(12); chk("t1_valid_early", int'(m_valid), 0);
        at(13); chk("t1_valid_13", int'(m_valid), 1);
                chk("t1_last_13", int'(m_last), 0);
        at(14); chk("t1_last_14", int'(m_last), 1);
        at(15); chk("t1_valid_15", int'(m_valid), 0);
                chk("t1_ovf", int'(overflow), 0);
                chk("t1_perr", int'(proto_err), 0);

        // Back-to-back strobes, second on the last capture beat
        do_reset("t2");
        m_ready = 1'b1;
        sched(10, 1);
        sched(12, 2);
        push_tile(1);
        push_tile(2);
        at(15); chk("t2_valid_15", int'(m_valid), 1);
        at(17); chk("t2_valid_17", int'(m_valid), 0);
                chk("t2_ovf", int'(overflow), 0);
                chk("t2_perr", int'(proto_err), 0);

        // Backpressure: third tile dropped
        do_reset("t3");
        m_ready = 1'b0;
        sched(10, 3);
        sched(13, 4);
        sched(16, 5);
        push_tile(3);
        push_tile(4);
        push_tile(6);
        at(16); chk("t3_ovf_16", int'(overflow), 0);
        at(17); chk("t3_ovf_17", int'(overflow), 1);
        at(25); chk("t3_valid_held", int'(m_valid), 1);
                chk("t3_busy_full", int'(busy), 1);
        at(30); m_ready = 1'b1;
        sched(40, 6);
        at(35); chk("t3_valid_drained", int'(m_valid), 0);
        at(43); chk("t3_valid_43", int'(m_valid), 1);
        at(50); chk("t3_ovf_sticky", int'(overflow), 1);
                chk("t3_valid_50", int'(m_valid), 0);

        // Release collision: bank 0 drains on the same edge as a new strobe
        do_reset("t4");
        m_ready = 1'b0;
        sched(10, 7);
        sched(13, 8);
        sched(21, 9);
        push_tile(7);
        push_tile(8);
        push_tile(9);
        at(20); m_ready = 1'b1;
        at(22); chk("t4_ovf_22", int'(overflow), 0);
        at(24); chk("t4_valid_24", int'(m_valid), 1);
        at(30); chk("t4_ovf_30", int'(overflow), 0);
                chk("t4_valid_30", int'(m_valid), 0);

        // Protocol error: strobe on a non-final capture beat
        do_reset("t5");
        m_ready = 1'b1;
        sched(10, 10);
        strobe_a[base + 11] = 1'b1;
        push_tile(10);
        at(11); chk("t5_perr_11", int'(proto_err), 0);
        at(12); chk("t5_perr_12", int'(proto_err), 1);
        at(13); chk("t5_valid_13", int'(m_valid), 1);
        at(20); chk("t5_valid_20", int'(m_valid), 0);
                chk("t5_ovf", int'(overflow), 0);
                chk("t5_busy", int'(busy), 0);

        // Reset in the middle of a capture
        do_reset("t6");
        m_ready = 1'b1;
        sched(10, 11);
        rst_a[base + 11] = 1'b1;
        sched(20, 12);
        push_tile(12);
        at(12); chk("t6_valid_12", int'(m_valid), 0);
                chk("t6_busy_12", int'(busy), 0);
                chk("t6_ovf_12", int'(overflow), 0);
                chk("t6_perr_12", int'(proto_err), 0);
        at(14); chk("t6_valid_14", int'(m_valid), 0);
        at(23); chk("t6_valid_23", int'(m_valid), 1);
        at(30); chk("t6_valid_30", int'(m_valid), 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_beats", mon_beats, 22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
